// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions: memory-stage FSM encoding, default timeout and
// the EX/MEM stage register layout seen by the memory access unit.
package mem_access_unit_pkg;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 16;
  localparam int MAX_WAIT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // EX/MEM stage register fields consumed by the memory stage
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              read;
    logic              write;
  } ex_mem_t;

  // Command held stable toward the memory for the whole access
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle between the pipeline/memory side (master) and the memory access
// unit (slave), plus the unit's status outputs.
interface mem_access_unit_if #(
  parameter int CNT_W = 16
);
  import mem_access_unit_pkg::*;

  // Handshakes: mem_req is a one-cycle strobe with mem_we/mem_addr/mem_wdata
  // stable from then until completion; mem_ack is a one-cycle completion pulse
  // with mem_rdata valid in that cycle; ld_valid is a one-cycle pulse with no
  // backpressure; stall high means the pipeline must hold EX/MEM and earlier.
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_read;
  logic              req_write;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [DATA_W-1:0] ld_data;
  logic              ld_valid;
  logic              timeout;
  logic              conflict;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output req_addr, req_wdata, req_read, req_write, mem_rdata, mem_ack,
    input  stall, mem_req, mem_we, mem_addr, mem_wdata, ld_data, ld_valid,
           timeout, conflict, stall_cycles
  );

  modport slave (
    input  req_addr, req_wdata, req_read, req_write, mem_rdata, mem_ack,
    output stall, mem_req, mem_we, mem_addr, mem_wdata, ld_data, ld_valid,
           timeout, conflict, stall_cycles
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns EX/MEM load/store requests into a strobe to a
// multi-cycle memory, stalls the pipeline meanwhile and times out lost acks.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus,
  output state_t             state
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  ex_mem_t           req;
  mem_cmd_t          cmd;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              accept;
  logic              mem_req_q;
  logic              ld_valid_q;
  logic              timeout_q;
  logic              conflict_q;
  logic [DATA_W-1:0] ld_data_q;

  assign req      = '{addr: bus.req_addr, wdata: bus.req_wdata,
                      read: bus.req_read, write: bus.req_write};
  assign accept   = (state == IDLE) && (req.read || req.write);
  assign wait_nxt = wait_cnt + WAIT_W'(1);

  // Stall rises in the accepting IDLE cycle itself so EX/MEM never advances
  // past an un-issued access; DONE releases it for exactly one cycle.
  assign bus.stall     = accept || (state == ISSUE) || (state == WAIT);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = cmd.we;
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_wdata = cmd.wdata;
  assign bus.ld_data   = ld_data_q;
  assign bus.ld_valid  = ld_valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.conflict  = conflict_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cmd        <= '0;
      wait_cnt   <= '0;
      mem_req_q  <= 1'b0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      timeout_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      mem_req_q  <= 1'b0;
      ld_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cmd       <= '{we: req.write, addr: req.addr, wdata: req.wdata};
            wait_cnt  <= '0;
            mem_req_q <= 1'b1;
            state     <= ISSUE;
            if (req.read && req.write) conflict_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.mem_ack) begin
            ld_data_q  <= bus.mem_rdata;
            ld_valid_q <= !cmd.we;
            state      <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_nxt;
          if (bus.mem_ack) begin
            ld_data_q  <= bus.mem_rdata;
            ld_valid_q <= !cmd.we;
            state      <= DONE;
          end else if (wait_nxt == WAIT_W'(MAX_WAIT)) begin
            ld_data_q  <= '0;
            ld_valid_q <= !cmd.we;
            timeout_q  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.stall),
    .count (bus.stall_cycles)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected memory commands and load
// results are queued at stimulus time and checked by a negedge monitor.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic   clk;
  logic   rst;
  state_t state;

  mem_access_unit_if #(.CNT_W(16)) bus ();

  mem_access_unit #(.MAX_WAIT(15), .CNT_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [15:0] exp_q[$];
  logic [32:0] cmd_q[$];
  int          n_checks;
  int          n_fail;
  int          exp_sc;
  logic [15:0] mon_ld;
  logic [32:0] mon_cmd;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    bus.mem_ack   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Starts at posedge+1 with the unit in IDLE; ack_wait<0 means never ack.
  task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input int ack_wait,
                        input logic [15:0] rd_val, input int exp_stalls,
                        input string tag);
    int stalls;
    bit done;
    stalls = 0;
    done   = 1'b0;
    cmd_q.push_back({wr, a, d});
    if (rd && !wr) exp_q.push_back((ack_wait < 0) ? 16'h0000 : rd_val);
    bus.req_read  = rd;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      bus.mem_ack   = (ack_wait >= 0) && (cyc == ack_wait + 1);
      bus.mem_rdata = bus.mem_ack ? rd_val : 16'hA5A5;
      @(negedge clk);
      if (cyc == 0) chk({tag, "_accept_state"}, 33'(state), 33'(IDLE));
      if (bus.stall) stalls++;
      else begin
        done = 1'b1;
        chk({tag, "_done_state"}, 33'(state), 33'(DONE));
      end
      @(posedge clk);
      #1;
    end
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    bus.mem_ack   = 1'b0;
    chk({tag, "_stalls"}, 33'(stalls), 33'(exp_stalls));
    exp_sc += exp_stalls;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_sc   = 0;
    rst           = 1'b0;
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 16'h0000;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;

    // monitor: pops expectations whenever the DUT presents an output
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          if (bus.ld_valid) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL ld_unexpected: got ld_valid with 0x%0h, expected none", bus.ld_data);
            end else begin
              mon_ld = exp_q.pop_front();
              chk("ld_data", 33'(bus.ld_data), 33'(mon_ld));
            end
          end
          if (bus.mem_req) begin
            if (cmd_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL mem_req_unexpected: got addr 0x%0h, expected no request", bus.mem_addr);
            end else begin
              mon_cmd = cmd_q.pop_front();
              chk("mem_cmd", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, mon_cmd);
            end
          end
        end
      end
    join_none

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state",     33'(state), 33'(IDLE));
    chk("rst_stall",     33'(bus.stall), 33'd0);
    chk("rst_mem_req",   33'(bus.mem_req), 33'd0);
    chk("rst_cmd",       {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 33'd0);
    chk("rst_ld",        {bus.ld_valid, bus.ld_data}, 33'd0);
    chk("rst_flags",     {bus.timeout, bus.conflict}, 33'd0);
    chk("rst_stall_cnt", 33'(bus.stall_cycles), 33'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // read, ack in ISSUE
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'hBEEF, 2, "rd_fast");
    chk("rd_fast_sc", 33'(bus.stall_cycles), 33'(exp_sc));

    // ack while IDLE is ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    @(negedge clk);
    chk("idle_ack_stall", 33'(bus.stall), 33'd0);
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_state", 33'(state), 33'(IDLE));
    chk("idle_ack_ld",    33'(bus.ld_data), 33'h0BEEF);
    idle(1);

    // write, ack on third WAIT cycle
    access(1'b0, 1'b1, 16'h0102, 16'h1234, 3, 16'h0000, 5, "wr_wait3");
    chk("wr_wait3_sc", 33'(bus.stall_cycles), 33'(exp_sc));
    idle(1);

    // read never acked: timeout after 15 WAIT cycles
    access(1'b1, 1'b0, 16'h0200, 16'h0000, -1, 16'h0000, 17, "rd_tmo");
    chk("rd_tmo_flag", 33'(bus.timeout), 33'd1);
    chk("rd_tmo_sc",   33'(bus.stall_cycles), 33'(exp_sc));
    idle(1);

    // read and write together: treated as a write
    access(1'b1, 1'b1, 16'h0280, 16'h5555, 1, 16'h9999, 3, "conflict");
    chk("conflict_flag", 33'(bus.conflict), 33'd1);
    chk("timeout_sticky1", 33'(bus.timeout), 33'd1);
    idle(1);

    // back-to-back reads
    access(1'b1, 1'b0, 16'h0300, 16'h0000, 0, 16'h1111, 2, "b2b_a");
    access(1'b1, 1'b0, 16'h0304, 16'h0000, 2, 16'h2222, 4, "b2b_b");
    @(negedge clk);
    chk("b2b_hold_ld",     33'(bus.ld_data), 33'h02222);
    chk("b2b_sc",          33'(bus.stall_cycles), 33'(exp_sc));
    chk("timeout_sticky2", 33'(bus.timeout), 33'd1);
    @(posedge clk);
    #1;

    // reset asserted during WAIT, late ack afterwards
    cmd_q.push_back({1'b0, 16'h0400, 16'h0000});
    bus.req_read  = 1'b1;
    bus.req_addr  = 16'h0400;
    bus.req_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstw_state_wait", 33'(state), 33'(WAIT));
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h7777;
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("rstw_state",  33'(state), 33'(IDLE));
    chk("rstw_sc",     33'(bus.stall_cycles), 33'd0);
    chk("rstw_ld",     {bus.ld_valid, bus.ld_data}, 33'd0);
    chk("rstw_stall",  33'(bus.stall), 33'd0);
    chk("rstw_flags",  {bus.timeout, bus.conflict}, 33'd0);
    idle(2);

    // final report
    chk("ld_queue_empty",  33'(exp_q.size()), 33'd0);
    chk("cmd_queue_empty", 33'(cmd_q.size()), 33'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
